// File: rtl/retire_rat.sv
// Retirement RAT: committed INT/FP arch->phys maps, superseded-tag release, flash restore on flush.
// Optional macro RETIRE_RAT_MAPBITS_EN enables the committed-map occupancy decode.
module retire_rat #(
  parameter int unsigned RETIRE_RATE        = 4,
  parameter int unsigned INT_PRF_LEN        = 7,
  parameter int unsigned FP_PRF_LEN         = 7,
  parameter int unsigned PRF_MAX_LEN        = 7,
  parameter int unsigned FLUSH_DRAIN_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [RETIRE_RATE-1:0]            Ret_Valid_bus,
  input  logic [RETIRE_RATE-1:0]            Ret_rdType_bus,
  input  logic [RETIRE_RATE*5-1:0]          Ret_rd_bus,
  input  logic [RETIRE_RATE*PRF_MAX_LEN-1:0] Ret_prd_bus,
  output logic                              Ret_Ready,
  input  logic                              Flush_Req,
  output logic                              Flush_Ack,
  output logic                              FlashWriteEnable,
  output logic [32*INT_PRF_LEN-1:0]         FlashWriteData_INT,
  output logic [32*FP_PRF_LEN-1:0]          FlashWriteData_FP,
  output logic [RETIRE_RATE-1:0]            Free_Valid_bus,
  output logic [RETIRE_RATE-1:0]            Free_Type_bus,
  output logic [RETIRE_RATE*PRF_MAX_LEN-1:0] Free_prd_bus,
  output logic [2**INT_PRF_LEN-1:0]         Int_CommittedMapBits,
  output logic [2**FP_PRF_LEN-1:0]          Fp_CommittedMapBits
);

  localparam int unsigned CW = (FLUSH_DRAIN_CYCLES > 1) ? $clog2(FLUSH_DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((FLUSH_DRAIN_CYCLES > 0) ? FLUSH_DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_FLASH, S_DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [INT_PRF_LEN-1:0] int_crat [32];
  logic [FP_PRF_LEN-1:0]  fp_crat  [32];
  logic [INT_PRF_LEN-1:0] int_nxt  [32];
  logic [FP_PRF_LEN-1:0]  fp_nxt   [32];
  logic [PRF_MAX_LEN-1:0] old_prd  [RETIRE_RATE];
  logic [RETIRE_RATE-1:0] eff;

  // Walking the ports in order against a running copy of the table gives each
  // slot the mapping left by the youngest older same-cycle writer, else the CRAT.
  always_comb begin
    int_nxt = int_crat;
    fp_nxt  = fp_crat;
    eff     = '0;
    for (int unsigned i = 0; i < RETIRE_RATE; i++) begin
      old_prd[i] = '0;
      if (Ret_rdType_bus[i]) begin
        old_prd[i] = PRF_MAX_LEN'(fp_nxt[Ret_rd_bus[i*5 +: 5]]);
        eff[i]     = Ret_Valid_bus[i] & Ret_Ready;
        if (eff[i])
          fp_nxt[Ret_rd_bus[i*5 +: 5]] = Ret_prd_bus[i*PRF_MAX_LEN +: FP_PRF_LEN];
      end else begin
        old_prd[i] = PRF_MAX_LEN'(int_nxt[Ret_rd_bus[i*5 +: 5]]);
        eff[i]     = Ret_Valid_bus[i] & Ret_Ready & (Ret_rd_bus[i*5 +: 5] != 5'd0);
        if (eff[i])
          int_nxt[Ret_rd_bus[i*5 +: 5]] = Ret_prd_bus[i*PRF_MAX_LEN +: INT_PRF_LEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++) begin
        int_crat[r] <= INT_PRF_LEN'(r);
        fp_crat[r]  <= FP_PRF_LEN'(r);
      end
      Free_Valid_bus <= '0;
      Free_Type_bus  <= '0;
      Free_prd_bus   <= '0;
    end else begin
      int_crat       <= int_nxt;
      fp_crat        <= fp_nxt;
      Free_Valid_bus <= eff;
      Free_Type_bus  <= Ret_rdType_bus;
      for (int unsigned i = 0; i < RETIRE_RATE; i++)
        Free_prd_bus[i*PRF_MAX_LEN +: PRF_MAX_LEN] <= old_prd[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    Ret_Ready        = 1'b0;
    FlashWriteEnable = 1'b0;
    Flush_Ack        = 1'b0;
    unique case (state)
      S_IDLE: begin
        Ret_Ready = 1'b1;
        if (Flush_Req) state_nxt = S_FLASH;
      end
      S_FLASH: begin
        FlashWriteEnable = 1'b1;
        cnt_nxt          = '0;
        if (FLUSH_DRAIN_CYCLES == 0) begin
          Flush_Ack = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          Flush_Ack = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    FlashWriteData_INT = '0;
    FlashWriteData_FP  = '0;
    for (int unsigned r = 0; r < 32; r++) begin
      FlashWriteData_INT[r*INT_PRF_LEN +: INT_PRF_LEN] = int_crat[r];
      FlashWriteData_FP[r*FP_PRF_LEN +: FP_PRF_LEN]    = fp_crat[r];
    end
  end

`ifdef RETIRE_RAT_MAPBITS_EN
  always_comb begin
    Int_CommittedMapBits = '0;
    Fp_CommittedMapBits  = '0;
    for (int unsigned r = 0; r < 32; r++) begin
      Int_CommittedMapBits[int_crat[r]] = 1'b1;
      Fp_CommittedMapBits[fp_crat[r]]   = 1'b1;
    end
  end
`else
  assign Int_CommittedMapBits = '0;
  assign Fp_CommittedMapBits  = '0;
`endif

endmodule
